// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg : shared UART constants and feeder FSM state encoding   (rev 1.0)
// -----------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;
  localparam int UART_ADDR_WIDTH = 4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } feeder_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_tx_feeder_if.sv
// -----------------------------------------------------------------------------
// uart_tx_feeder_if : producer-side and transmitter-side feeder signals (rev 1.0)
// -----------------------------------------------------------------------------
`default_nettype none

interface uart_tx_feeder_if
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int ADDR_WIDTH = UART_ADDR_WIDTH
);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  full;
  logic                  empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  ovf_clr;
  logic                  tx_start;
  logic [DATA_WIDTH-1:0] din;
  logic                  tx_done;
  logic                  busy;

  // Producer plus transmitter environment around the feeder.
  modport master (
    output wr_en, wr_data, ovf_clr, tx_done,
    input  full, empty, count, overflow, tx_start, din, busy
  );

  modport slave (
    input  wr_en, wr_data, ovf_clr, tx_done,
    output full, empty, count, overflow, tx_start, din, busy
  );

endinterface

`default_nettype wire

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo : single-clock FIFO with same-cycle push/pop support     (rev 1.0)
// -----------------------------------------------------------------------------
`default_nettype none

module sync_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int ADDR_WIDTH = UART_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  do_push;
  logic                  do_pop;

  // Guards live here so count can never leave 0..DEPTH whatever the caller does.
  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = do_push ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;

endmodule

`default_nettype wire

// File: rtl/uart_tx_feeder.sv
// -----------------------------------------------------------------------------
// uart_tx_feeder : FIFO-buffered launcher for a UART TX serializer   (rev 1.0)
// -----------------------------------------------------------------------------
`default_nettype none

module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int ADDR_WIDTH = UART_ADDR_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  uart_tx_feeder_if.slave  bus
);

  feeder_state_e         state_q, state_d;
  logic                  tx_start_q, tx_start_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  busy_q, busy_d;
  logic                  overflow_q, overflow_d;
  logic                  tx_done_dly_q, tx_done_dly_d;

  logic                  done_edge;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_head;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (bus.wr_en),
    .pop     (fifo_pop),
    .wr_data (bus.wr_data),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (bus.count)
  );

  always_comb begin
    tx_done_dly_d = bus.tx_done;
    done_edge     = bus.tx_done & ~tx_done_dly_q;
    state_d       = state_q;
    tx_start_d    = 1'b0;
    din_d         = din_q;
    fifo_pop      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          din_d      = fifo_head;
          tx_start_d = 1'b1;
          state_d    = ST_SEND;
        end
      end
      // A level left high from the previous frame is not an edge, so only a
      // fresh completion releases the FSM.
      ST_SEND: begin
        if (done_edge) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_SEND);

    // A dropped push wins over a clear in the same cycle.
    if (bus.wr_en && fifo_full) begin
      overflow_d = 1'b1;
    end else if (bus.ovf_clr) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      tx_start_q    <= 1'b0;
      din_q         <= '0;
      busy_q        <= 1'b0;
      overflow_q    <= 1'b0;
      tx_done_dly_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tx_start_q    <= tx_start_d;
      din_q         <= din_d;
      busy_q        <= busy_d;
      overflow_q    <= overflow_d;
      tx_done_dly_q <= tx_done_dly_d;
    end
  end

  assign bus.full     = fifo_full;
  assign bus.empty    = fifo_empty;
  assign bus.overflow = overflow_q;
  assign bus.tx_start = tx_start_q;
  assign bus.din      = din_q;
  assign bus.busy     = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_feeder.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_feeder : scoreboarded random/directed bench for uart_tx_feeder (rev 1.0)
// -----------------------------------------------------------------------------
`default_nettype none

module tb_uart_tx_feeder;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk;
  logic reset;

  uart_tx_feeder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  uart_tx_feeder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int launches = 0;

  // Reference: a byte queue plus an "in flight" flag; one launch whenever the
  // line is free and something is waiting, freed by a rising tx_done.
  bit [DW-1:0] m_q[$];
  bit [DW-1:0] sb_q[$];
  bit          m_busy, m_ovf, m_start, m_prev, m_full, m_launch;
  bit [DW-1:0] m_din;

  bit          tx_auto  = 1'b0;
  int          tx_delay = 4;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q.delete();
      sb_q.delete();
      m_busy  = 1'b0;
      m_ovf   = 1'b0;
      m_start = 1'b0;
      m_prev  = 1'b0;
      m_din   = '0;
    end else begin
      m_full   = (m_q.size() == DEPTH);
      m_launch = !m_busy && (m_q.size() != 0);
      if (bus.wr_en && m_full) m_ovf = 1'b1;
      else if (bus.ovf_clr)    m_ovf = 1'b0;
      if (m_launch) begin
        m_din  = m_q.pop_front();
        m_busy = 1'b1;
      end else if (m_busy && bus.tx_done && !m_prev) begin
        m_busy = 1'b0;
      end
      m_start = m_launch;
      if (bus.wr_en && !m_full) begin
        m_q.push_back(bus.wr_data);
        sb_q.push_back(bus.wr_data);
      end
      m_prev = bus.tx_done;
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      chk("count",    int'(bus.count),    m_q.size());
      chk("empty",    int'(bus.empty),    int'(m_q.size() == 0));
      chk("full",     int'(bus.full),     int'(m_q.size() == DEPTH));
      chk("busy",     int'(bus.busy),     int'(m_busy));
      chk("overflow", int'(bus.overflow), int'(m_ovf));
      chk("tx_start", int'(bus.tx_start), int'(m_start));
      chk("din_hold", int'(bus.din),      int'(m_din));
      if (bus.tx_start === 1'b1) begin
        launches++;
        chk("launch_expected", int'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) chk("din_order", int'(bus.din), int'(sb_q.pop_front()));
      end
    end
  end

  // Transmitter model: drops done on accepting a launch, raises it tx_delay cycles later.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_auto && bus.tx_start === 1'b1) begin
        @(posedge clk); #1 bus.tx_done = 1'b0;
        repeat (tx_delay) @(posedge clk);
        #1 bus.tx_done = 1'b1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push(input bit [DW-1:0] b);
    bus.wr_en = 1'b1; bus.wr_data = b;
    step();
    bus.wr_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic wait_idle(input int bound);
    int ok = 0;
    for (int i = 0; i < bound; i++) begin
      step();
      if (m_q.size() == 0 && !m_busy) begin ok = 1; break; end
    end
    chk("idle_within_bound", ok, 1);
  endtask

  // Releases whatever frame is in flight, then lets the transmitter model run.
  task automatic drain(input int delay);
    tx_delay = delay;
    bus.tx_done = 1'b0; step();
    bus.tx_done = 1'b1; tx_auto = 1'b1;
    wait_idle(2000);
    tx_auto = 1'b0;
    chk("drain_sb_empty", sb_q.size(), 0);
  endtask

  int l0;

  initial begin
    bus.wr_en = 1'b0; bus.wr_data = '0; bus.ovf_clr = 1'b0; bus.tx_done = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_count",    int'(bus.count),    0);
    chk("rst_empty",    int'(bus.empty),    1);
    chk("rst_full",     int'(bus.full),     0);
    chk("rst_overflow", int'(bus.overflow), 0);
    chk("rst_tx_start", int'(bus.tx_start), 0);
    chk("rst_din",      int'(bus.din),      0);
    chk("rst_busy",     int'(bus.busy),     0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    step();

    // Single byte, manual done pulse
    l0 = launches;
    push(8'hA5);
    step();
    chk("t1_tx_start", int'(bus.tx_start), 1);
    chk("t1_din",      int'(bus.din),      8'hA5);
    chk("t1_busy",     int'(bus.busy),     1);
    chk("t1_empty",    int'(bus.empty),    1);
    step();
    chk("t1_pulse_len", int'(bus.tx_start), 0);
    repeat (3) step();
    bus.tx_done = 1'b1; step(); bus.tx_done = 1'b0; step();
    chk("t1_busy_after_done", int'(bus.busy), 0);
    chk("t1_launches", launches - l0, 1);

    // Three-byte burst against a 160-cycle transmitter
    l0 = launches;
    tx_delay = 160; tx_auto = 1'b1;
    push(8'h11); push(8'h22); push(8'h33);
    wait_idle(1000);
    tx_auto = 1'b0;
    chk("t2_launches", launches - l0, 3);

    // Fill and overflow with the line stalled
    bus.tx_done = 1'b0; step();
    for (int i = 0; i < 17; i++) push(8'($urandom_range(0, 127)));
    push(8'hFF);
    chk("t3_count",    int'(bus.count),    16);
    chk("t3_full",     int'(bus.full),     1);
    chk("t3_overflow", int'(bus.overflow), 1);
    bus.ovf_clr = 1'b1; step(); bus.ovf_clr = 1'b0;
    chk("t3_ovf_clr",  int'(bus.overflow), 0);
    drain(3);

    // tx_done held high from reset
    tx_auto = 1'b0; bus.tx_done = 1'b1;
    do_reset();
    step();
    l0 = launches;
    push(8'h5A);
    repeat (20) step();
    chk("t4_single_launch", launches - l0, 1);
    chk("t4_busy_held",     int'(bus.busy), 1);
    bus.tx_done = 1'b0; step();
    bus.tx_done = 1'b1; step(); step();
    chk("t4_busy_released", int'(bus.busy), 0);

    // Push and pop in the same cycle at count 5
    bus.tx_done = 1'b0; step();
    for (int i = 0; i < 6; i++) push(8'(8'h40 + i));
    step(); step();
    chk("t5_count_pre", int'(bus.count), 5);
    bus.tx_done = 1'b1; step();
    bus.wr_en = 1'b1; bus.wr_data = 8'h77; step(); bus.wr_en = 1'b0;
    chk("t5_count_same", int'(bus.count),    5);
    chk("t5_launch",     int'(bus.tx_start), 1);
    drain(2);

    // Asynchronous reset mid-SEND with 4 queued
    bus.tx_done = 1'b0; step();
    for (int i = 0; i < 5; i++) push(8'(8'h60 + i));
    chk("t6_count_pre", int'(bus.count), 4);
    @(posedge clk); #3 reset = 1'b0; #1;
    chk("t6_count",    int'(bus.count),    0);
    chk("t6_empty",    int'(bus.empty),    1);
    chk("t6_busy",     int'(bus.busy),     0);
    chk("t6_tx_start", int'(bus.tx_start), 0);
    @(posedge clk); #1 reset = 1'b1;
    l0 = launches;
    repeat (30) step();
    chk("t6_no_launch", launches - l0, 0);

    // Random traffic against the randomly paced transmitter
    tx_delay = 5; tx_auto = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) tx_delay = $urandom_range(1, 12);
      bus.wr_en   = ($urandom_range(0, 99) < 45);
      bus.wr_data = 8'($urandom);
      bus.ovf_clr = ($urandom_range(0, 19) == 0);
      step();
    end
    bus.wr_en = 1'b0; bus.ovf_clr = 1'b0;
    wait_idle(4000);
    tx_auto = 1'b0;
    repeat (5) step();
    chk("final_sb_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
- Buffers bytes written by the system side (bus or command logic) in a synchronous FIFO.
- Launches them one at a time into the UART transmitter directly downstream, using that transmitter's tx_start/din/tx_done handshake.
- Lets the producer burst data without polling the serial line.
- Sits between the register/interface logic and the UART TX serializer.

Parameters:
- DATA_WIDTH, 8, width of each queued word; must match the transmitter's data width.
- ADDR_WIDTH, 4, FIFO address bits; depth = 2**ADDR_WIDTH (16).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- wr_en  in  1  push wr_data this cycle.
- wr_data  in  DATA_WIDTH  word to queue.
- full  out  1  FIFO holds 2**ADDR_WIDTH words.
- empty  out  1  FIFO holds 0 words.
- count  out  ADDR_WIDTH+1  current occupancy, 0..2**ADDR_WIDTH.
- overflow  out  1  sticky; set when a push is dropped.
- ovf_clr  in  1  clears overflow.
- tx_start  out  1  one-cycle launch pulse to the transmitter.
- din  out  DATA_WIDTH  word presented with tx_start; held until the next launch.
- tx_done  in  1  transmitter done level; high after stop bit, cleared by the transmitter after it accepts tx_start.
- busy  out  1  a word is in flight (state SEND).

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO pointers and count = 0; empty=1, full=0.
  - overflow=0, tx_start=0, din=0, busy=0.
  - tx_done_d=0; FSM = IDLE.
  - Reset mid-transfer discards all queued data. The in-flight serial frame belongs to the transmitter, which shares the reset.
- Push rules:
  - Push occurs when wr_en=1 and full=0.
  - wr_en=1 with full=1 drops the word and sets overflow, even if a pop occurs in the same cycle. full is judged on the registered value.
- Pop: occurs only on the IDLE->SEND transition.
- Simultaneous push and pop: count unchanged; pointers both advance.
- Pointers wrap modulo 2**ADDR_WIDTH. full/empty derive from count.
- overflow:
  - Set has priority over ovf_clr in the same cycle.
  - Otherwise ovf_clr=1 clears it next cycle.
- Edge detect: tx_done_d registers tx_done each cycle; done_edge = tx_done & ~tx_done_d.
- FSM (2 states, registered outputs):
  - IDLE:
    - If empty=0: pop head; register din=head and tx_start=1 for exactly one cycle; go to SEND.
    - Else remain in IDLE with tx_start=0.
  - SEND:
    - busy=1, tx_start=0.
    - On done_edge, return to IDLE. The next launch can occur on the following edge, so there is a 1-cycle minimum gap between tx_start pulses.
  - A stale high tx_done from the previous frame never produces done_edge, because the transmitter drops it after accepting tx_start.
- Latency: with the FIFO empty and FSM in IDLE, push at edge N gives empty=0 after N, and tx_start=1/din valid during cycle N+1..N+2 (edge N+1 registers them).
- din is stable from the tx_start cycle until the next launch. The transmitter samples it in the tx_start cycle.
- tx_done high while in IDLE is ignored.
- count saturation: never exceeds 2**ADDR_WIDTH; never underflows (pop gated by empty).

Decomposition:
- Shared package uart_pkg:
  - FSM state localparams (ST_IDLE, ST_SEND).
  - Default DATA_WIDTH and ADDR_WIDTH constants, shared with the transmitter and receiver.
- One sub-module, sync_fifo:
  - Parameterised DATA_WIDTH/ADDR_WIDTH.
  - Registered memory, wr/rd pointers, count, full/empty, same-cycle push/pop.
  - Instanced by uart_tx_feeder.
- FSM, edge detector and overflow flag live in the top.

Test Plan:
- Reset, then a single push of 0xA5 at edge N:
  - tx_start high for exactly one cycle at N+1 with din=0xA5; busy=1; empty=1 afterwards.
  - After a tx_done 0->1 pulse, busy=0.
- Push 0x11, 0x22, 0x33 back-to-back with the transmitter model producing done after 160 cycles each:
  - Three tx_start pulses, din in order 0x11, 0x22, 0x33.
  - Each launch occurs ≥1 cycle after the prior done_edge; no launch happens while busy.
- Fill 16 words while tx_done is held low, then push 0xFF:
  - full=1, count=16, overflow=1.
  - 0xFF is never transmitted. ovf_clr then gives overflow=0.
- Hold tx_done=1 continuously from reset, then push 0x5A:
  - tx_start fires once.
  - The FSM stays in SEND until tx_done goes 0 then 1. No double launch.
- Push and FSM pop in the same cycle at count=5: count stays 5, and order is preserved.
- Assert reset=0 asynchronously mid-SEND with 4 words queued:
  - Outputs clear immediately without waiting for clk: count=0, empty=1, busy=0, tx_start=0.
  - No further launches after release until a new push.
